nn_layer_reader: RTL
====================

Name: nn_layer_reader

Overview:
Controller and reader at the output end of a fully connected layer. The layer computes one weighted sum per neuron under `enable` and raises `finish` when done. This block:
- starts the layer and holds its enable;
- waits for finish, with a watchdog;
- snapshots all neuron sums into a local buffer;
- streams them out one word per valid/ready handshake, with optional ReLU;
- clears the layer for the next pass.

It sits between a layer instance and the next layer or a host read-out path.

Parameters:
OUTPUT_NUMBER, 10, number of neuron sums read from the layer (must be ≥1)
WIDTH, 11, signed word width of each sum
TIMEOUT, 1024, max cycles in RUN waiting for nn_finish before aborting (≥1)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to run the layer; sampled only in IDLE
relu_en  in  1  apply ReLU on read-out; latched on accepted start
nn_enable  out  1  enable to layer; high only in RUN
nn_clear_n  out  1  active-low clear to layer accumulators
nn_finish  in  1  layer completion flag
nn_sum  in  OUTPUT_NUMBER*WIDTH  flattened signed sums; neuron k at bits [k*WIDTH +: WIDTH]
out_data  out  WIDTH  signed streamed sum
out_index  out  $clog2(OUTPUT_NUMBER) (min 1)  neuron index of out_data
out_valid  out  1  out_data/out_index valid
out_ready  in  1  downstream accepts when high with out_valid
out_last  out  1  high with out_valid on final word
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on completion (normal or abort)
timeout_err  out  1  sticky abort flag; cleared on next accepted start

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at clk edge), overriding everything including mid-stream:
  - state ← IDLE;
  - nn_enable, out_valid, out_last, busy, done, timeout_err, out_data, out_index ← 0;
  - nn_clear_n ← 0;
  - buffer, watchdog and index counters ← 0.
- No partial stream resumes after reset.
- States: IDLE, RUN, STREAM, CLEAR.
- IDLE:
  - nn_clear_n=1, nn_enable=0.
  - start=1 → RUN next cycle: latch relu_en, clear timeout_err, watchdog←0, nn_enable←1.
  - start in any other state is ignored.
- RUN:
  - nn_enable=1; watchdog increments every cycle.
  - nn_finish=1 on an edge → capture all OUTPUT_NUMBER words of nn_sum into the buffer on that same edge; nn_enable←0; out_index←0; → STREAM.
  - nn_finish=0 and watchdog==TIMEOUT-1 → timeout_err←1; nn_enable←0; → CLEAR (no stream).
  - If finish and timeout coincide, finish wins.
- STREAM:
  - out_valid=1; out_data = buffer[out_index], except when latched relu_en=1 and the value is negative, then out_data=0.
  - out_last = (out_index==OUTPUT_NUMBER-1).
  - out_data, out_index and out_last stay stable while out_valid=1 and out_ready=0.
  - On handshake (out_valid & out_ready) with !out_last: out_index+1, next word presented the following cycle (one word per cycle at full throughput).
  - On handshake with out_last: out_valid←0 → CLEAR.
  - Buffer is not affected by nn_sum changes after capture.
- CLEAR: exactly one cycle.
  - nn_clear_n=0, busy=1.
  - done pulses 1 on the edge leaving CLEAR, i.e. high during the first IDLE cycle.
  - → IDLE. start arriving in that first IDLE cycle is accepted.
- Latency with out_ready held 1, start accepted at edge 0, layer finishes at edge F:
  - first word valid after edge F;
  - last word handshakes at edge F+OUTPUT_NUMBER;
  - CLEAR in the following cycle, then done.
- Arithmetic: no rescaling or rounding; ReLU is the only value transform. Sign bit = bit WIDTH-1.

Test Plan:
1. Reset, start=1 relu_en=0, model asserts nn_finish 202 cycles later with sums k*10-30 (k=0..9) → nn_enable high exactly 202 cycles; stream -30,-20,…,60 with out_index 0..9; out_last only on index 9; one nn_clear_n low cycle; done pulse; timeout_err=0.
2. Same sums, relu_en=1 → stream 0,0,0,0,10,20,…,60.
3. relu_en=0, out_ready toggling 1,0,0,1,… → each word held stable while stalled; no word dropped or duplicated; exactly 10 handshakes.
4. TIMEOUT=16, nn_finish never asserted → nn_enable drops after 16 RUN cycles; no out_valid; timeout_err=1; done pulse. Next start clears timeout_err.
5. rst_n=0 for one cycle during STREAM at index 4 → next cycle out_valid=0, busy=0, nn_clear_n=0, state IDLE. A later start restarts from index 0.
6. start held high continuously across a full run → a second run begins in the cycle done is high; starts during RUN/STREAM are ignored; nn_sum changed during STREAM does not alter streamed values.

Source files
------------

// File: rtl/nn_layer_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nn_layer_reader : runs a layer, snapshots its neuron sums, streams them out
// Revision 1.0
// ---------------------------------------------------------------------------
module nn_layer_reader #(
  parameter int OUTPUT_NUMBER = 10,
  parameter int WIDTH         = 11,
  parameter int TIMEOUT       = 1024,
  localparam int IW = (OUTPUT_NUMBER > 1) ? $clog2(OUTPUT_NUMBER) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            relu_en,
  output logic                            nn_enable,
  output logic                            nn_clear_n,
  input  logic                            nn_finish,
  input  logic [OUTPUT_NUMBER*WIDTH-1:0]  nn_sum,
  output logic signed [WIDTH-1:0]         out_data,
  output logic [IW-1:0]                   out_index,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout_err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  localparam logic [IW-1:0] c_LAST_IDX = IW'(OUTPUT_NUMBER - 1);
  localparam logic [WW-1:0] c_WD_MAX   = WW'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic             r_nn_enable;
  logic             r_clear_n;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
  logic             r_done;
  logic             r_terr;
  logic             r_relu;
  logic [WIDTH-1:0] r_data;
  logic [IW-1:0]    r_index;
  logic [WW-1:0]    r_wdog;
  logic [WIDTH-1:0] r_buf [OUTPUT_NUMBER];

  logic [IW-1:0]    w_next_idx;

  assign w_next_idx  = r_index + 1'b1;

  assign nn_enable   = r_nn_enable;
  assign nn_clear_n  = r_clear_n;
  assign out_data    = r_data;
  assign out_index   = r_index;
  assign out_valid   = r_valid;
  assign out_last    = r_last;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_terr;

  function automatic logic [WIDTH-1:0] f_relu(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? '0 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_nn_enable <= 1'b0;
      r_clear_n   <= 1'b0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_terr      <= 1'b0;
      r_relu      <= 1'b0;
      r_data      <= '0;
      r_index     <= '0;
      r_wdog      <= '0;
      for (int k = 0; k < OUTPUT_NUMBER; k++) r_buf[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clear_n   <= 1'b1;
          r_nn_enable <= 1'b0;
          if (start) begin
            r_state     <= S_RUN;
            r_relu      <= relu_en;
            r_terr      <= 1'b0;
            r_wdog      <= '0;
            r_nn_enable <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_RUN: begin
          r_wdog <= r_wdog + 1'b1;
          // Finish takes priority over a watchdog expiry in the same cycle.
          if (nn_finish) begin
            for (int k = 0; k < OUTPUT_NUMBER; k++) r_buf[k] <= nn_sum[k*WIDTH +: WIDTH];
            r_nn_enable <= 1'b0;
            r_index     <= '0;
            r_data      <= f_relu(nn_sum[WIDTH-1:0], r_relu);
            r_valid     <= 1'b1;
            r_last      <= (OUTPUT_NUMBER == 1);
            r_state     <= S_STREAM;
          end else if (r_wdog == c_WD_MAX) begin
            r_terr      <= 1'b1;
            r_nn_enable <= 1'b0;
            r_clear_n   <= 1'b0;
            r_state     <= S_CLEAR;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (r_last) begin
              r_valid   <= 1'b0;
              r_last    <= 1'b0;
              r_clear_n <= 1'b0;
              r_state   <= S_CLEAR;
            end else begin
              r_index <= w_next_idx;
              r_data  <= f_relu(r_buf[w_next_idx], r_relu);
              r_last  <= (w_next_idx == c_LAST_IDX);
            end
          end
        end
        S_CLEAR: begin
          r_clear_n <= 1'b1;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
